layer_deserializer: RTL
=======================

Name: layer_deserializer

Overview:
- Receives the serial word stream leaving a layer: one DEPTH-bit activation per cycle, SIZE words per frame, first word = neuron 0.
- Reassembles each frame into a parallel SIZE x DEPTH vector and presents it downstream with a valid/ready handshake.
- Double-buffered: a collect buffer fills while the output holding register waits for acceptance.
- Sits between a layer's serial output and a host readback or next-stage parallel consumer.

Parameters:
- SIZE, 3, words (neurons) per frame; must be >= 2.
- DEPTH, 8, bits per word.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data carries a word this cycle.
- in_first  input  1  qualified by in_valid; marks word 0 of a frame.
- in_data  input  DEPTH  serial word.
- out_valid  output  1  out_data holds a complete frame.
- out_ready  input  1  downstream accepts the frame this cycle.
- out_data  output  SIZE*DEPTH  packed [SIZE-1:0][DEPTH-1:0]; index i = word i of the frame.
- overrun  output  1  sticky error flag; cleared only by reset.
- frame_cnt  output  16  number of frames handed to the output register; wraps at 2^16.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE. idx = 0. Collect buffer = 0.
  - out_valid = 0, out_data = 0, overrun = 0, frame_cnt = 0.
  - Reset mid-frame discards the partial frame. Reset mid-handshake drops the pending output.
- Collect FSM states: IDLE, COLLECT, HOLD.
  - IDLE:
    - in_valid & in_first -> write word 0, idx = 1, go to COLLECT.
    - in_valid & !in_first -> ignore the word (no error).
  - COLLECT:
    - in_valid -> write buf[idx], idx + 1.
    - When word SIZE-1 is written: if the output register is free (out_valid = 0, or out_valid & out_ready this same cycle), transfer buf and word SIZE-1 directly into out_data next edge and go to IDLE; otherwise go to HOLD.
    - in_valid & in_first in COLLECT -> restart: the word becomes word 0, idx = 1, overrun set.
    - Idle cycles (in_valid = 0) are allowed mid-frame and do not advance idx.
  - HOLD:
    - The full frame waits in the collect buffer.
    - When the output register frees, transfer the frame and go to IDLE.
    - in_valid in HOLD -> word dropped, overrun set. A dropped in_first stays dropped; the next frame is not captured until a new in_first arrives after leaving HOLD.
- Output register:
  - Load sets out_valid = 1 and increments frame_cnt in the same edge.
  - Transfer latency: last word in at edge N -> out_valid high after edge N+1 (one cycle) when the output is free.
  - out_valid & out_ready -> out_valid = 0 next edge, unless a transfer reloads the register in the same edge. Back-to-back frames are lossless when out_ready is held high.
  - out_data is stable while out_valid = 1 and out_ready = 0.
  - out_ready while out_valid = 0 has no effect.
- Widths:
  - idx is $clog2(SIZE) bits and never exceeds SIZE-1.
  - No arithmetic on data; words are stored verbatim.

Decomposition:
- Shared package layer_pkg:
  - enum of deserializer states.
  - Default DEPTH and SIZE constants, shared with the layer.
  - typedef for the packed frame vector.
- Natural sub-module: frame_out_reg, the single-entry valid/ready holding register with load and accept.

Test Plan:
- SIZE=3, DEPTH=8, out_ready=1; words 0x11 (first), 0x22, 0x33 on consecutive cycles -> out_valid one cycle after 0x33; out_data[0]=0x11, [1]=0x22, [2]=0x33; frame_cnt=1.
- out_ready=0; two consecutive frames (A = 1,2,3, then B = 4,5,6) -> A held stable, B in HOLD. Raise out_ready -> A accepted, B appears the next cycle, frame_cnt=2, overrun=0.
- out_ready=0 with one frame held and one in HOLD; send a third frame -> overrun=1, third frame absent after the drain.
- Frame 0xA0, 0xA1, then in_first with 0xB0, 0xB1, 0xB2 -> output 0xB0, 0xB1, 0xB2; overrun=1.
- Gaps of 2 idle cycles between words, plus stray words without in_first while in IDLE -> only the framed words are captured, in the correct order.
- Assert rst low after word 1 of a frame -> all outputs 0 immediately; a fresh frame after release is captured correctly.

Source files
------------

// File: rtl/layer_pkg.sv
// layer_pkg: constants, deserializer states and frame type shared by the layer datapath.
package layer_pkg;
   localparam int LAYER_SIZE  = 3;
   localparam int LAYER_DEPTH = 8;
   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} deser_state_t;
   typedef logic [LAYER_SIZE-1:0][LAYER_DEPTH-1:0] layer_frame_t;
endpackage

// File: rtl/layer_deserializer_frame_out_reg.sv
// frame_out_reg: single-entry valid/ready holding register for a parallel frame.
module frame_out_reg import layer_pkg::*; #(
   parameter int SIZE  = LAYER_SIZE,
   parameter int DEPTH = LAYER_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [SIZE-1:0][DEPTH-1:0] load_data,
   input  logic                       ready,
   output logic                       valid,
   output logic [SIZE-1:0][DEPTH-1:0] data,
   output logic                       free,
   output logic [15:0]                cnt
);
   // A load may coincide with acceptance of the current frame, so free looks at ready too.
   assign free = !valid || ready;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         valid <= 1'b0;
         data  <= '0;
         cnt   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         cnt   <= cnt + 1'b1;
      end else if (ready) begin
         valid <= 1'b0;
      end
endmodule

// File: rtl/layer_deserializer.sv
// layer_deserializer: reassembles a serial word stream into SIZE-word frames, double-buffered
// behind a valid/ready output register.
module layer_deserializer import layer_pkg::*; #(
   parameter int SIZE  = LAYER_SIZE,
   parameter int DEPTH = LAYER_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       in_first,
   input  logic [DEPTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SIZE-1:0][DEPTH-1:0] out_data,
   output logic                       overrun,
   output logic [15:0]                frame_cnt
);
   localparam int IW = $clog2(SIZE);
   localparam logic [IW-1:0] LAST = IW'(SIZE - 1);
   deser_state_t state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [SIZE-1:0][DEPTH-1:0] col_buf, col_buf_n;
   logic load, free, ovr_set;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         idx     <= '0;
         col_buf <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         col_buf <= col_buf_n;
         overrun <= overrun || ovr_set;
      end
   // The output register always loads col_buf_n, so the last word bypasses the buffer.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      col_buf_n = col_buf;
      load      = 1'b0;
      ovr_set   = 1'b0;
      case (state)
         IDLE: if (in_valid && in_first) begin
            col_buf_n[0] = in_data;
            idx_n        = IW'(1);
            state_n      = COLLECT;
         end
         COLLECT: if (in_valid) begin
            if (in_first) begin
               col_buf_n[0] = in_data;
               idx_n        = IW'(1);
               ovr_set      = 1'b1;
            end else begin
               col_buf_n[idx] = in_data;
               idx_n          = idx == LAST ? '0 : idx + 1'b1;
               if (idx == LAST) begin
                  load    = free;
                  state_n = free ? IDLE : HOLD;
               end
            end
         end
         HOLD: begin
            ovr_set = in_valid;
            load    = free;
            state_n = free ? IDLE : HOLD;
         end
         default: state_n = IDLE;
      endcase
   end
   frame_out_reg #(.SIZE(SIZE), .DEPTH(DEPTH)) u_out (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (col_buf_n),
      .ready     (out_ready),
      .valid     (out_valid),
      .data      (out_data),
      .free      (free),
      .cnt       (frame_cnt)
   );
endmodule
